// File: rtl/aes_ctr_stream_ctrl.sv
// AES-256 counter-mode streaming controller: drives an external AES block core
// and XORs keystream onto a valid/ready plaintext stream. Optional AES_CTR_PREFETCH_EN.
module aes_ctr_stream_ctrl #(
  parameter int CTR_W = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [255:0]     key_i,
  input  logic [127:0]     iv_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_err_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [127:0]     in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     out_data_o,
  output logic             core_start_o,
  output logic [255:0]     core_key_o,
  output logic [127:0]     core_block_o,
  input  logic             core_done_i,
  input  logic [127:0]     core_result_i
);

  localparam int BW = LEN_W - 3;

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_XOR, S_OUT} state_e;

  state_e         state_q, state_d;
  logic [255:0]   key_q, key_d;
  logic [127:0]   ctr_q, ctr_d;
  logic [127:0]   ks_q, ks_d;
  logic [127:0]   out_data_q, out_data_d;
  logic           core_start_q, core_start_d;
  logic           done_q, done_d;
  logic           wrap_q, wrap_d;
  logic [BW-1:0]  blk_left_q, blk_left_d;
  logic [3:0]     last_bytes_q, last_bytes_d;
`ifdef AES_CTR_PREFETCH_EN
  logic           ks_vld_q, ks_vld_d;
  logic [127:0]   nxt_q, nxt_d;
  logic           nxt_vld_q, nxt_vld_d;
  logic           pend_q, pend_d;
  logic [BW-1:0]  req_left_q, req_left_d;
`endif

  logic [BW-1:0]  nblk;
  logic [127:0]   ctr_inc;
  logic           ctr_wraps;
  logic           is_last;
  logic [127:0]   keep_mask;
  logic           in_fire;
  logic           out_fire;

  assign nblk      = {1'b0, len_i[LEN_W-1:4]} + BW'(|len_i[3:0]);
  assign ctr_wraps = &ctr_q[CTR_W-1:0];
  assign is_last   = (blk_left_q == BW'(1));

  // Only the low CTR_W bits of the counter block ever move.
  always_comb begin
    ctr_inc = ctr_q;
    ctr_inc[CTR_W-1:0] = ctr_q[CTR_W-1:0] + CTR_W'(1);
  end

  always_comb begin
    keep_mask = '1;
    if (is_last && (last_bytes_q != 4'd0)) begin
      for (int b = 0; b < 16; b++) begin
        if (b >= int'(last_bytes_q)) keep_mask[127-8*b -: 8] = 8'h00;
      end
    end
  end

`ifdef AES_CTR_PREFETCH_EN
  assign in_ready_o = (state_q == S_XOR) && ks_vld_q;
`else
  assign in_ready_o = (state_q == S_XOR);
`endif
  assign out_valid_o  = (state_q == S_OUT);
  assign busy_o       = (state_q != S_IDLE);
  assign in_fire      = in_ready_o && in_valid_i;
  assign out_fire     = out_valid_o && out_ready_i;
  assign done_o       = done_q;
  assign wrap_err_o   = wrap_q;
  assign out_data_o   = out_data_q;
  assign core_start_o = core_start_q;
  assign core_key_o   = key_q;
  assign core_block_o = ctr_q;

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    ctr_d        = ctr_q;
    ks_d         = ks_q;
    out_data_d   = out_data_q;
    core_start_d = 1'b0;
    done_d       = 1'b0;
    wrap_d       = wrap_q;
    blk_left_d   = blk_left_q;
    last_bytes_d = last_bytes_q;
`ifdef AES_CTR_PREFETCH_EN
    ks_vld_d     = ks_vld_q;
    nxt_d        = nxt_q;
    nxt_vld_d    = nxt_vld_q;
    pend_d       = pend_q;
    req_left_d   = req_left_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          key_d        = key_i;
          wrap_d       = 1'b0;
          last_bytes_d = len_i[3:0];
          blk_left_d   = nblk;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            ctr_d        = iv_i;
            core_start_d = 1'b1;
            state_d      = S_GEN;
`ifdef AES_CTR_PREFETCH_EN
            pend_d     = 1'b1;
            req_left_d = nblk - BW'(1);
            ks_vld_d   = 1'b0;
            nxt_vld_d  = 1'b0;
`endif
          end
        end
      end
      S_GEN: begin
`ifdef AES_CTR_PREFETCH_EN
        if (core_done_i && pend_q) state_d = S_XOR;
`else
        if (core_done_i) begin
          ks_d    = core_result_i;
          state_d = S_XOR;
        end
`endif
      end
      S_XOR: begin
        if (in_fire) begin
          out_data_d = (in_data_i ^ ks_q) & keep_mask;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (out_fire) begin
          if (is_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            blk_left_d = blk_left_q - BW'(1);
`ifdef AES_CTR_PREFETCH_EN
            state_d = S_XOR;
`else
            ctr_d        = ctr_inc;
            wrap_d       = wrap_q | ctr_wraps;
            core_start_d = 1'b1;
            state_d      = S_GEN;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef AES_CTR_PREFETCH_EN
    // Consume first, then capture, so a keystream arriving alongside an
    // input handshake lands in the slot that was just freed.
    if (state_q != S_IDLE) begin
      if (in_fire) begin
        ks_d      = nxt_q;
        ks_vld_d  = nxt_vld_q;
        nxt_vld_d = 1'b0;
      end
      if (core_done_i && pend_q) begin
        pend_d = 1'b0;
        if (!ks_vld_d) begin
          ks_d     = core_result_i;
          ks_vld_d = 1'b1;
        end else begin
          nxt_d     = core_result_i;
          nxt_vld_d = 1'b1;
        end
      end
      if (!pend_d && (req_left_q != '0) && !nxt_vld_d) begin
        core_start_d = 1'b1;
        pend_d       = 1'b1;
        ctr_d        = ctr_inc;
        wrap_d       = wrap_q | ctr_wraps;
        req_left_d   = req_left_q - BW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      ctr_q        <= '0;
      ks_q         <= '0;
      out_data_q   <= '0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      wrap_q       <= 1'b0;
      blk_left_q   <= '0;
      last_bytes_q <= '0;
`ifdef AES_CTR_PREFETCH_EN
      ks_vld_q     <= 1'b0;
      nxt_q        <= '0;
      nxt_vld_q    <= 1'b0;
      pend_q       <= 1'b0;
      req_left_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      ctr_q        <= ctr_d;
      ks_q         <= ks_d;
      out_data_q   <= out_data_d;
      core_start_q <= core_start_d;
      done_q       <= done_d;
      wrap_q       <= wrap_d;
      blk_left_q   <= blk_left_d;
      last_bytes_q <= last_bytes_d;
`ifdef AES_CTR_PREFETCH_EN
      ks_vld_q     <= ks_vld_d;
      nxt_q        <= nxt_d;
      nxt_vld_q    <= nxt_vld_d;
      pend_q       <= pend_d;
      req_left_q   <= req_left_d;
`endif
    end
  end

endmodule

// File: doc/aes_ctr_stream_ctrl.md
# aes_ctr_stream_ctrl

Parametrised AES-256 counter-mode streaming controller. It accepts a key, IV and byte length per message, and issues counter blocks to the existing AES-256 block core through a start/done port. Plaintext arrives as 128-bit blocks on a valid/ready stream, and ciphertext leaves on a second valid/ready stream, with the final partial block masked. It replaces the fixed-width, whole-message ctr_encryption datapath at the top of the crypto path.

## Interface
- CTR_W, 32: width of the incrementing counter field (low bits of the counter block); 1..128
- LEN_W, 16: width of the message byte-length input
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle message start; accepted only in IDLE
- key  in  256  AES-256 key; latched on accepted start
- iv  in  128  initial counter block; latched on accepted start
- len  in  LEN_W  message length in bytes; latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last output handshake
- wrap_err  out  1  sticky; counter field wrapped during the message; cleared on accepted start
- in_valid / in_ready  in/out  1  plaintext handshake
- in_data  in  128  plaintext block; byte 0 = bits [127:120]
- out_valid / out_ready  out/in  1  ciphertext handshake
- out_data  out  128  ciphertext block
- core_start  out  1  one-cycle request to the AES core
- core_key  out  256  latched key, held for the whole message
- core_block  out  128  counter block, stable from core_start until core_done
- core_done  in  1  one-cycle result-valid pulse from the core
- core_result  in  128  keystream block, valid with core_done

## Operation
- nblk = ceil(len/16). last_bytes = len mod 16, where 0 means a full block.
- States:
  - IDLE: start → GEN when len≠0. When len=0, done pulses the next cycle and the core is never started.
  - GEN: core_start was issued on entry. core_done captures the keystream → XOR.
  - XOR: in_ready=1. On in handshake, out_data = in_data ^ keystream → OUT.
  - OUT: out_valid=1. On out handshake: last block → IDLE with done; otherwise counter increments → GEN.
- Counter update: low CTR_W bits increment modulo 2^CTR_W. Upper 128−CTR_W bits are never modified. A rollover from all-ones to zero sets wrap_err; processing continues.
- Last block with last_bytes=k≠0: output bytes k..15 are forced to zero. Input bytes beyond k are ignored.
- start outside IDLE is ignored. core_done outside GEN is ignored. That includes a late done arriving after reset.
- rst at any point: state → IDLE and all outputs → 0. The in-flight message is discarded.

## Timing
- Reset values: busy, done, wrap_err, in_ready, out_valid, core_start = 0; out_data, core_block, core_key = 0.
- Accepted start at cycle t: busy=1 and core_start=1 with core_block=iv at t+1.
- Keystream captured on core_done at cycle d: in_ready=1 from d+1.
- In handshake at cycle h: out_valid=1 at h+1, with out_data registered. in_ready=0 from h+1.
- out_data and out_valid are held stable while out_ready=0.
- Out handshake at cycle o:
  - Non-last block: core_start at o+1.
  - Last block: done=1 and busy=0 at o+1. A new start is accepted from o+1.
- Minimum per-block latency (non-prefetch) = core latency + 3 cycles.

## Configuration
- AES_CTR_PREFETCH_EN defined:
  - Adds a one-deep keystream buffer.
  - The request for block i+1 issues the cycle after keystream i is captured, when i+1 < nblk, overlapping the core with the XOR/OUT states.
  - in_ready additionally requires the current keystream to be valid.
  - Output ordering and data are identical to the undefined case.
- Undefined: strictly sequential GEN → XOR → OUT per block, with no buffer.

## Test plan
- Key 000102…1e1f, iv 00112233445566778899aabbccddeeff, len=16, plaintext all zero → out_data 8ea2b7ca516745bfeafc49904b496089, then done.
- Same key/iv, len=48 → core_block sequence …ccddeeff, …ccddef00, …ccddef01. Upper 96 bits unchanged; 3 outputs, then done.
- iv low 32 bits ffffffff, CTR_W=32, len=32 → second core_block 001122334455667788 99aabb00000000 (i.e. upper bits kept, low field 00000000); wrap_err=1 after done.
- len=20 with all-ff plaintext:
  - Block 2 keeps output bytes 0..3 as keystream^ff.
  - Bytes 4..15 of block 2 are 00.
- out_ready held low for 10 cycles → out_data stable and no new in_ready. len=0 → done at t+1 with no core_start.
- rst asserted in XOR, then a stray core_done delivered → outputs 0, state IDLE, core_done ignored. A following start runs normally.
